// File: rtl/up_axi_master_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | up_axi_master_pkg                                                    |
// | State encodings and AXI constants shared by the up-bus AXI master.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package up_axi_master_pkg;

    localparam int c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_WR      = 3'd1;
    localparam state_t c_ST_WR_RESP = 3'd2;
    localparam state_t c_ST_RD_ADDR = 3'd3;
    localparam state_t c_ST_RD_DATA = 3'd4;

    localparam logic [1:0]  c_AXI_RESP_OKAY = 2'b00;
    localparam logic [2:0]  c_AXI_PROT      = 3'b000;
    localparam logic [3:0]  c_AXI_WSTRB     = 4'hF;
    localparam logic [31:0] c_TIMEOUT_RDATA = 32'hDEAD_DEAD;

endpackage
`default_nettype wire

// File: rtl/up_axi_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | up_axi_master                                                        |
// | Turns up-bus read/write pulses into single AXI4-Lite transactions.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module up_axi_master
    import up_axi_master_pkg::*;
#(
    parameter int AXI_ADDRESS_WIDTH = 16,
    parameter int ADDRESS_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                         up_clk,
    input  logic                         up_rstn,
    input  logic                         up_wreq,
    input  logic [ADDRESS_WIDTH-1:0]     up_waddr,
    input  logic [31:0]                  up_wdata,
    output logic                         up_wack,
    input  logic                         up_rreq,
    input  logic [ADDRESS_WIDTH-1:0]     up_raddr,
    output logic [31:0]                  up_rdata,
    output logic                         up_rack,
    output logic                         up_busy,
    output logic                         up_err,
    output logic                         up_drop,
    output logic                         m_axi_awvalid,
    input  logic                         m_axi_awready,
    output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]                   m_axi_awprot,
    output logic                         m_axi_wvalid,
    input  logic                         m_axi_wready,
    output logic [31:0]                  m_axi_wdata,
    output logic [3:0]                   m_axi_wstrb,
    input  logic                         m_axi_bvalid,
    output logic                         m_axi_bready,
    input  logic [1:0]                   m_axi_bresp,
    output logic                         m_axi_arvalid,
    input  logic                         m_axi_arready,
    output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]                   m_axi_arprot,
    input  logic                         m_axi_rvalid,
    output logic                         m_axi_rready,
    input  logic [31:0]                  m_axi_rdata,
    input  logic [1:0]                   m_axi_rresp
);

    localparam int                 c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TMO   = c_CNT_W'(TIMEOUT_CYCLES);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [c_CNT_W-1:0]       r_cnt;
    logic [ADDRESS_WIDTH-1:0] r_waddr;
    logic [ADDRESS_WIDTH-1:0] r_raddr;
    logic [31:0]              r_wdata;
    logic [31:0]              r_rdata;
    logic                     r_rd_pend;
    logic                     r_awvalid;
    logic                     r_wvalid;
    logic                     r_bready;
    logic                     r_arvalid;
    logic                     r_rready;
    logic                     r_wack;
    logic                     r_rack;
    logic                     r_err;
    logic                     r_drop;
    logic                     w_timeout;
    logic                     w_aw_done;
    logic                     w_w_done;

    assign w_aw_done = !r_awvalid || m_axi_awready;
    assign w_w_done  = !r_wvalid  || m_axi_wready;

    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (r_rd_pend || (up_rreq && !up_wreq)) begin
                    w_state_nxt = c_ST_RD_ADDR;
                end else if (up_wreq) begin
                    w_state_nxt = c_ST_WR;
                end
            end
            c_ST_WR: begin
                if (w_timeout) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_aw_done && w_w_done) begin
                    w_state_nxt = c_ST_WR_RESP;
                end
            end
            c_ST_WR_RESP: begin
                if (m_axi_bvalid || w_timeout) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_RD_ADDR: begin
                if (w_timeout) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (m_axi_arready) begin
                    w_state_nxt = c_ST_RD_DATA;
                end
            end
            c_ST_RD_DATA: begin
                if (m_axi_rvalid || w_timeout) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // A read queued behind a write keeps the block busy through the write ack
    always_comb begin
        up_busy   = (r_state != c_ST_IDLE) || r_rd_pend;
        w_timeout = (r_cnt == c_TMO);
    end

    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            r_cnt     <= '0;
            r_waddr   <= '0;
            r_raddr   <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_rd_pend <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_wack    <= 1'b0;
            r_rack    <= 1'b0;
            r_err     <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_wack <= 1'b0;
            r_rack <= 1'b0;
            r_err  <= 1'b0;
            if (up_busy && (up_wreq || up_rreq)) begin
                r_drop <= 1'b1;
            end
            if (r_state == c_ST_IDLE) begin
                r_cnt <= '0;
            end else if (!w_timeout) begin
                r_cnt <= r_cnt + 1'b1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (r_rd_pend) begin
                        r_rd_pend <= 1'b0;
                        r_arvalid <= 1'b1;
                    end else if (up_wreq) begin
                        r_waddr   <= up_waddr;
                        r_wdata   <= up_wdata;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        if (up_rreq) begin
                            r_raddr   <= up_raddr;
                            r_rd_pend <= 1'b1;
                        end
                    end else if (up_rreq) begin
                        r_raddr   <= up_raddr;
                        r_arvalid <= 1'b1;
                    end
                end
                c_ST_WR: begin
                    if (w_timeout) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_wack    <= 1'b1;
                        r_err     <= 1'b1;
                    end else begin
                        if (m_axi_awready) begin
                            r_awvalid <= 1'b0;
                        end
                        if (m_axi_wready) begin
                            r_wvalid <= 1'b0;
                        end
                        if (w_aw_done && w_w_done) begin
                            r_bready <= 1'b1;
                        end
                    end
                end
                c_ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        r_bready <= 1'b0;
                        r_wack   <= 1'b1;
                        r_err    <= (m_axi_bresp != c_AXI_RESP_OKAY);
                    end else if (w_timeout) begin
                        r_bready <= 1'b0;
                        r_wack   <= 1'b1;
                        r_err    <= 1'b1;
                    end
                end
                c_ST_RD_ADDR: begin
                    if (w_timeout) begin
                        r_arvalid <= 1'b0;
                        r_rack    <= 1'b1;
                        r_err     <= 1'b1;
                        r_rdata   <= c_TIMEOUT_RDATA;
                    end else if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                c_ST_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        r_rready <= 1'b0;
                        r_rack   <= 1'b1;
                        r_rdata  <= m_axi_rdata;
                        r_err    <= (m_axi_rresp != c_AXI_RESP_OKAY);
                    end else if (w_timeout) begin
                        r_rready <= 1'b0;
                        r_rack   <= 1'b1;
                        r_err    <= 1'b1;
                        r_rdata  <= c_TIMEOUT_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign up_wack       = r_wack;
    assign up_rack       = r_rack;
    assign up_rdata      = r_rdata;
    assign up_err        = r_err;
    assign up_drop       = r_drop;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_awaddr  = AXI_ADDRESS_WIDTH'({r_waddr, 2'b00});
    assign m_axi_awprot  = c_AXI_PROT;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = c_AXI_WSTRB;
    assign m_axi_bready  = r_bready;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_araddr  = AXI_ADDRESS_WIDTH'({r_raddr, 2'b00});
    assign m_axi_arprot  = c_AXI_PROT;
    assign m_axi_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_up_axi_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_up_axi_master                                                     |
// | Directed bench with a configurable AXI4-Lite slave and ack scoreboard.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_up_axi_master;

    logic        up_clk = 1'b0;
    logic        up_rstn = 1'b0;
    logic        up_wreq = 1'b0, up_rreq = 1'b0;
    logic [13:0] up_waddr = '0, up_raddr = '0;
    logic [31:0] up_wdata = '0;
    logic        up_wack, up_rack, up_busy, up_err, up_drop;
    logic [31:0] up_rdata;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic [15:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;

    always #5 up_clk = ~up_clk;

    up_axi_master #(
        .AXI_ADDRESS_WIDTH(16),
        .ADDRESS_WIDTH    (14),
        .TIMEOUT_CYCLES   (16)
    ) dut (
        .up_clk(up_clk), .up_rstn(up_rstn),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
        .up_busy(up_busy), .up_err(up_err), .up_drop(up_drop),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model: ready after N cycles of valid, response after N cycles
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    int          aw_wait, w_wait, ar_wait, b_timer, r_timer;
    logic        got_aw, got_w, got_ar, s_bvalid, s_rvalid;
    logic        mute = 1'b0, late_rvalid = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = '0;

    assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_dly);
    assign m_axi_wready  = m_axi_wvalid  && (w_wait  >= w_dly);
    assign m_axi_arready = m_axi_arvalid && (ar_wait >= ar_dly);
    assign m_axi_bvalid  = s_bvalid;
    assign m_axi_rvalid  = s_rvalid | late_rvalid;
    assign m_axi_bresp   = cfg_bresp;
    assign m_axi_rresp   = cfg_rresp;
    assign m_axi_rdata   = cfg_rdata;

    wire aw_hs = m_axi_awvalid && m_axi_awready;
    wire w_hs  = m_axi_wvalid  && m_axi_wready;
    wire ar_hs = m_axi_arvalid && m_axi_arready;

    always @(posedge up_clk) begin
        if (!up_rstn) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_timer <= 0; r_timer <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0;
            s_bvalid <= 1'b0; s_rvalid <= 1'b0;
        end else begin
            if (aw_hs) begin aw_wait <= 0; got_aw <= 1'b1; end
            else if (m_axi_awvalid) aw_wait <= aw_wait + 1;
            if (w_hs) begin w_wait <= 0; got_w <= 1'b1; end
            else if (m_axi_wvalid) w_wait <= w_wait + 1;
            if (ar_hs) begin ar_wait <= 0; got_ar <= 1'b1; end
            else if (m_axi_arvalid) ar_wait <= ar_wait + 1;
            if (s_bvalid && m_axi_bready) s_bvalid <= 1'b0;
            else if (!s_bvalid && (got_aw || aw_hs) && (got_w || w_hs)) begin
                if (b_timer >= b_dly) begin
                    s_bvalid <= 1'b1; b_timer <= 0; got_aw <= 1'b0; got_w <= 1'b0;
                end else b_timer <= b_timer + 1;
            end
            if (s_rvalid && m_axi_rready) s_rvalid <= 1'b0;
            else if (!s_rvalid && (got_ar || ar_hs)) begin
                if (r_timer >= r_dly) begin
                    s_rvalid <= 1'b1; r_timer <= 0; got_ar <= 1'b0;
                end else r_timer <= r_timer + 1;
            end
            if (mute) begin
                s_bvalid <= 1'b0; s_rvalid <= 1'b0;
                got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0;
            end
        end
    end

    typedef struct packed {
        logic        rd;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int          wack_cnt = 0, rack_cnt = 0, b_hs_cnt = 0;
    logic [15:0] seen_awaddr = '0, seen_araddr = '0;
    logic [31:0] seen_wdata = '0;
    logic [3:0]  seen_wstrb = '0;
    logic [2:0]  seen_awprot = '1, seen_arprot = '1;
    logic        prev_aw = 1'b0, prev_ar = 1'b0, prev_w = 1'b0, prev_rstn = 1'b0;
    logic [15:0] prev_awaddr, prev_araddr;
    logic [31:0] prev_wdata;

    always @(negedge up_clk) begin
        exp_t e;
        if (up_rstn && prev_rstn) begin
            if (prev_aw) chk("aw_hold", {m_axi_awvalid, m_axi_awaddr}, {1'b1, prev_awaddr});
            if (prev_w)  chk("w_hold",  {m_axi_wvalid,  m_axi_wdata},  {1'b1, prev_wdata});
            if (prev_ar) chk("ar_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, prev_araddr});
        end
        prev_rstn   = up_rstn;
        prev_aw     = m_axi_awvalid && !m_axi_awready;
        prev_w      = m_axi_wvalid  && !m_axi_wready;
        prev_ar     = m_axi_arvalid && !m_axi_arready;
        prev_awaddr = m_axi_awaddr;
        prev_wdata  = m_axi_wdata;
        prev_araddr = m_axi_araddr;
        if (up_rstn) begin
            if (aw_hs) begin seen_awaddr = m_axi_awaddr; seen_awprot = m_axi_awprot; end
            if (w_hs)  begin seen_wdata = m_axi_wdata; seen_wstrb = m_axi_wstrb; end
            if (ar_hs) begin seen_araddr = m_axi_araddr; seen_arprot = m_axi_arprot; end
            if (m_axi_bvalid && m_axi_bready) b_hs_cnt++;
            if (up_wack || up_rack) begin
                if (up_wack) wack_cnt++;
                if (up_rack) rack_cnt++;
                if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
                else begin
                    e = sb.pop_front();
                    chk("ack_kind", {63'd0, up_rack}, {63'd0, e.rd});
                    chk("ack_err", {63'd0, up_err}, {63'd0, e.err});
                    if (up_rack) chk("rdata", {32'd0, up_rdata}, {32'd0, e.data});
                end
            end
        end
    end

    task automatic step();
        @(negedge up_clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic r, input logic [13:0] wa,
                         input logic [31:0] wd, input logic [13:0] ra);
        up_wreq = w; up_rreq = r; up_waddr = wa; up_wdata = wd; up_raddr = ra;
        step();
        up_wreq = 1'b0; up_rreq = 1'b0;
    endtask

    task automatic wait_ack(input logic rd, input int start, output int lat);
        lat = start;
        for (int k = 0; k < 200; k++) begin
            step();
            lat++;
            if (rd ? up_rack : up_wack) return;
        end
        chk("ack_wait_expired", 64'd0, 64'd1);
    endtask

    wire [9:0] ctl_vec = {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                          m_axi_rready, up_wack, up_rack, up_err, up_busy, up_drop};

    initial begin
        int lat, b0, w0, r0;

        // Reset
        up_rstn = 1'b0;
        repeat (3) step();
        chk("reset_ctl", 64'(ctl_vec), 64'd0);
        chk("reset_rdata", 64'(up_rdata), 64'd0);
        up_rstn = 1'b1;
        step();

        // Zero-wait write
        sb.push_back('{rd: 1'b0, err: 1'b0, data: 32'h0});
        issue(1'b1, 1'b0, 14'h010, 32'hA5A5_0001, 14'h0);
        wait_ack(1'b0, 1, lat);
        chk("wr_latency", 64'(lat), 64'd3);
        chk("wr_busy_after", 64'(up_busy), 64'd0);
        chk("wr_awaddr", 64'(seen_awaddr), 64'h0040);
        chk("wr_wdata", 64'(seen_wdata), 64'hA5A5_0001);
        chk("wr_wstrb_prot", 64'({seen_wstrb, seen_awprot}), 64'h78);

        // Read with delayed rvalid
        r_dly = 5; cfg_rdata = 32'h1234_5678;
        sb.push_back('{rd: 1'b1, err: 1'b0, data: 32'h1234_5678});
        issue(1'b0, 1'b1, 14'h0, 32'h0, 14'h020);
        wait_ack(1'b1, 1, lat);
        chk("rd_busy_after", 64'(up_busy), 64'd0);
        chk("rd_araddr_prot", 64'({seen_araddr, seen_arprot}), 64'({16'h0080, 3'b000}));
        cfg_rdata = 32'h0;
        repeat (2) step();
        chk("rd_hold", 64'(up_rdata), 64'h1234_5678);
        r_dly = 0;

        // W accepted before AW, slave error response
        aw_dly = 4; cfg_bresp = 2'b10;
        b0 = b_hs_cnt; w0 = wack_cnt;
        sb.push_back('{rd: 1'b0, err: 1'b1, data: 32'h0});
        issue(1'b1, 1'b0, 14'h07F, 32'h3333_3333, 14'h0);
        chk("split_both_valid", 64'({m_axi_awvalid, m_axi_wvalid}), 64'b11);
        step();
        chk("split_w_first", 64'({m_axi_awvalid, m_axi_wvalid}), 64'b10);
        wait_ack(1'b0, 2, lat);
        chk("split_awaddr", 64'(seen_awaddr), 64'h01FC);
        repeat (3) step();
        chk("split_one_b", 64'(b_hs_cnt - b0), 64'd1);
        chk("split_one_wack", 64'(wack_cnt - w0), 64'd1);
        aw_dly = 0; cfg_bresp = 2'b00;

        // Simultaneous write and read
        cfg_rdata = 32'h0BAD_F00D;
        w0 = wack_cnt; r0 = rack_cnt;
        sb.push_back('{rd: 1'b0, err: 1'b0, data: 32'h0});
        sb.push_back('{rd: 1'b1, err: 1'b0, data: 32'h0BAD_F00D});
        issue(1'b1, 1'b1, 14'h004, 32'h0000_CAFE, 14'h008);
        wait_ack(1'b0, 1, lat);
        chk("sim_rack_not_yet", 64'(rack_cnt - r0), 64'd0);
        chk("sim_busy_pending", 64'(up_busy), 64'd1);
        wait_ack(1'b1, 0, lat);
        chk("sim_rd_gap", 64'(lat), 64'd3);
        chk("sim_araddr", 64'(seen_araddr), 64'h0020);
        chk("sim_awaddr_wdata", 64'({seen_awaddr, seen_wdata}), 64'({16'h0010, 32'h0000_CAFE}));
        chk("sim_no_drop", 64'(up_drop), 64'd0);

        // Read timeout with drop and late rvalid
        mute = 1'b1;
        sb.push_back('{rd: 1'b1, err: 1'b1, data: 32'hDEAD_DEAD});
        issue(1'b0, 1'b1, 14'h0, 32'h0, 14'h030);
        step();
        up_rreq = 1'b1; up_raddr = 14'h031;
        step();
        up_rreq = 1'b0;
        chk("busy_drop", 64'(up_drop), 64'd1);
        wait_ack(1'b1, 3, lat);
        chk("tmo_latency", 64'(lat), 64'd18);
        r0 = rack_cnt;
        late_rvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("late_rready", 64'(m_axi_rready), 64'd0);
        end
        late_rvalid = 1'b0;
        step();
        chk("late_no_rack", 64'(rack_cnt - r0), 64'd0);
        chk("tmo_rdata_hold", 64'(up_rdata), 64'hDEAD_DEAD);
        chk("drop_sticky", 64'(up_drop), 64'd1);
        mute = 1'b0;

        // Reset in WR_RESP, then a fresh write
        b_dly = 10;
        issue(1'b1, 1'b0, 14'h005, 32'h5555_5555, 14'h0);
        repeat (2) step();
        chk("mid_wr_resp_bready", 64'(m_axi_bready), 64'd1);
        up_rstn = 1'b0;
        step();
        chk("midrst_ctl", 64'(ctl_vec), 64'd0);
        chk("midrst_rdata", 64'(up_rdata), 64'd0);
        up_rstn = 1'b1; b_dly = 0;
        step();
        sb.push_back('{rd: 1'b0, err: 1'b0, data: 32'h0});
        issue(1'b1, 1'b0, 14'h011, 32'h0000_600D, 14'h0);
        wait_ack(1'b0, 1, lat);
        chk("post_rst_latency", 64'(lat), 64'd3);
        chk("post_rst_awaddr", 64'(seen_awaddr), 64'h0044);
        repeat (3) step();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
